div_share_arbiter: RTL and testbench

- Round-robin arbiter that time-shares one iterative fixed-point divider (16.16, `N_in`/`D_in`/`in_valid`/`ready`/`out_valid`/`out` interface) among NUM_REQ requesters.
- Typical requesters: the Cholesky division step, the inverse back-substitution engine and normalisation logic.
- Exactly one division is in flight at a time. Each requester gets a valid/ready request channel and a valid/ready response channel.

---
 rtl/div_share_arbiter.sv | 163 ++++++++++++++++
 tb/tb_div_share_arbiter.sv | 500 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_share_arbiter.sv
// div_share_arbiter: round-robin time-sharing of one iterative divider.
// Optional watchdog in WAIT is enabled with the DIV_TIMEOUT_EN macro.
module div_share_arbiter #(
    parameter int NUM_REQ        = 4,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_n,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_d,
    output logic [NUM_REQ-1:0]            resp_valid,
    input  logic [NUM_REQ-1:0]            resp_ready,
    output logic [DATA_WIDTH-1:0]         resp_data,
    output logic                          resp_err,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id,
    output logic                          busy,
    output logic [DATA_WIDTH-1:0]         div_n,
    output logic [DATA_WIDTH-1:0]         div_d,
    output logic                          div_in_valid,
    input  logic                          div_ready,
    input  logic                          div_out_valid,
    input  logic [DATA_WIDTH-1:0]         div_out
);

    localparam int IDW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]            r_state;
    logic [IDW-1:0]        r_rr_ptr;
    logic [IDW-1:0]        r_grant;
    logic [DATA_WIDTH-1:0] r_div_n;
    logic [DATA_WIDTH-1:0] r_div_d;
    logic [DATA_WIDTH-1:0] r_resp_data;

    logic                  w_found;
    logic [IDW-1:0]        w_winner;
    logic [IDW:0]          w_sum;
    logic [DATA_WIDTH-1:0] w_sel_n;
    logic [DATA_WIDTH-1:0] w_sel_d;
    logic                  w_resp_hs;

`ifdef DIV_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_tmo_cnt;
    logic          r_resp_err;
    assign resp_err = r_resp_err;
`else
    assign resp_err = 1'b0;
`endif

    // Winner search from rr_ptr upward with wrap; lowest offset wins.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_sum    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, r_rr_ptr} + (IDW+1)'(k);
            if (w_sum >= (IDW+1)'(NUM_REQ)) begin
                w_sum = w_sum - (IDW+1)'(NUM_REQ);
            end
            if (req_valid[w_sum[IDW-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_sum[IDW-1:0];
            end
        end
    end

    // Per-requester decode of handshakes and operand selection.
    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        w_resp_hs  = 1'b0;
        w_sel_n    = '0;
        w_sel_d    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_winner == IDW'(i)) begin
                req_ready[i] = (r_state == S_IDLE) && w_found;
                w_sel_n      = req_n[i*DATA_WIDTH +: DATA_WIDTH];
                w_sel_d      = req_d[i*DATA_WIDTH +: DATA_WIDTH];
            end
            if (r_grant == IDW'(i)) begin
                resp_valid[i] = (r_state == S_RESP);
                w_resp_hs     = resp_ready[i];
            end
        end
    end

    // Job FSM: accept, issue to divider, wait for result, deliver.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_rr_ptr    <= '0;
            r_grant     <= '0;
            r_div_n     <= '0;
            r_div_d     <= '0;
            r_resp_data <= '0;
`ifdef DIV_TIMEOUT_EN
            r_tmo_cnt   <= '0;
            r_resp_err  <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant <= w_winner;
                        r_div_n <= w_sel_n;
                        r_div_d <= w_sel_d;
                        r_state <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (div_ready) begin
                        r_state <= S_WAIT;
`ifdef DIV_TIMEOUT_EN
                        r_tmo_cnt <= '0;
`endif
                    end
                end
                S_WAIT: begin
                    if (div_out_valid) begin
                        r_resp_data <= div_out;
                        r_state     <= S_RESP;
`ifdef DIV_TIMEOUT_EN
                        r_resp_err  <= 1'b0;
                    end else if (r_tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                        r_resp_data <= {1'b0, {(DATA_WIDTH-1){1'b1}}};
                        r_resp_err  <= 1'b1;
                        r_state     <= S_RESP;
                    end else begin
                        r_tmo_cnt <= r_tmo_cnt + 1'b1;
`endif
                    end
                end
                S_RESP: begin
                    if (w_resp_hs) begin
                        if (r_grant == IDW'(NUM_REQ - 1)) begin
                            r_rr_ptr <= '0;
                        end else begin
                            r_rr_ptr <= r_grant + 1'b1;
                        end
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign grant_id     = r_grant;
    assign busy         = (r_state != S_IDLE);
    assign div_n        = r_div_n;
    assign div_d        = r_div_d;
    assign div_in_valid = (r_state == S_ISSUE);
    assign resp_data    = r_resp_data;

endmodule

// File: tb/tb_div_share_arbiter.sv
// tb_div_share_arbiter: vector table, directed corner cases and a
// randomized run against a transaction-level arbiter model.
module tb_div_share_arbiter;

    localparam int NR = 4;
    localparam int DW = 32;

    logic          clk;
    logic          rst;
    logic [NR-1:0] req_valid;
    logic [NR-1:0] req_ready;
    logic [NR*DW-1:0] req_n;
    logic [NR*DW-1:0] req_d;
    logic [NR-1:0] resp_valid;
    logic [NR-1:0] resp_ready;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic [1:0]    grant_id;
    logic          busy;
    logic [DW-1:0] div_n;
    logic [DW-1:0] div_d;
    logic          div_in_valid;
    logic          div_ready;
    logic          div_out_valid;
    logic [DW-1:0] div_out;

    div_share_arbiter #(
        .NUM_REQ(NR),
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_n(req_n),
        .req_d(req_d),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data(resp_data),
        .resp_err(resp_err),
        .grant_id(grant_id),
        .busy(busy),
        .div_n(div_n),
        .div_d(div_d),
        .div_in_valid(div_in_valid),
        .div_ready(div_ready),
        .div_out_valid(div_out_valid),
        .div_out(div_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // 16.16 unsigned quotient; divide-by-zero saturates to all ones.
    function automatic logic [31:0] ref_div(logic [31:0] n, logic [31:0] d);
        logic [63:0] q;
        if (d == 32'h0) return 32'hFFFF_FFFF;
        q = {16'h0, n, 16'h0} / {32'h0, d};
        return q[31:0];
    endfunction

    function automatic logic [3:0] oh(int i);
        return 4'(1) << i;
    endfunction

    function automatic int first_idx(logic [3:0] v);
        for (int i = 0; i < NR; i++) if (v[i]) return i;
        return 0;
    endfunction

    // Divider stub: fixed or random latency, optional stall and mute.
    int dv_lat = 1;
    int dv_stall = 0;
    int dv_cnt = 0;
    bit dv_mute = 0;
    bit dv_rand = 0;
    logic [31:0] dv_res;

    initial begin
        div_ready = 1'b1;
        div_out_valid = 1'b0;
        div_out = '0;
        forever begin
            @(negedge clk);
            div_out_valid = 1'b0;
            if (dv_cnt > 0) begin
                dv_cnt--;
                if (dv_cnt == 0 && !dv_mute) begin
                    div_out_valid = 1'b1;
                    div_out = dv_res;
                end
            end
            if (dv_rand) begin
                div_ready = ($urandom_range(0, 2) != 0) && (dv_cnt == 0);
            end else begin
                div_ready = (dv_stall == 0) && (dv_cnt == 0);
                if (dv_stall > 0) dv_stall--;
            end
            if (div_in_valid && div_ready) begin
                dv_res = ref_div(div_n, div_d);
                dv_cnt = dv_rand ? int'($urandom_range(1, 5)) : dv_lat;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(int i, logic [31:0] n, logic [31:0] d);
        req_n[i*DW +: DW] = n;
        req_d[i*DW +: DW] = d;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    task automatic drain();
        req_valid = '0;
        resp_ready = '1;
        for (int c = 0; c < 100; c++) begin
            if (!busy) break;
            cyc();
        end
        chk("drain_idle", busy, 0);
    endtask

    task automatic run_single(int idx, logic [31:0] n, logic [31:0] d,
                              logic [31:0] q, string tag);
        bit seen;
        set_req(idx, n, d);
        resp_ready = oh(idx);
        req_valid = oh(idx);
        #1;
        chk({tag, "_req_ready"}, req_ready, oh(idx));
        cyc();
        chk({tag, "_ready_pulse"}, req_ready, 0);
        req_valid = '0;
        seen = 0;
        for (int c = 0; c < 100; c++) begin
            if (resp_valid != 0) begin
                seen = 1;
                break;
            end
            cyc();
        end
        chk({tag, "_resp_seen"}, seen, 1);
        chk({tag, "_resp_valid"}, resp_valid, oh(idx));
        chk({tag, "_resp_data"}, resp_data, q);
        chk({tag, "_resp_err"}, resp_err, 0);
        chk({tag, "_grant_id"}, grant_id, idx);
        cyc();
        chk({tag, "_idle_after"}, busy, 0);
    endtask

    int gq[$];

    task automatic collect(int want, string tag);
        int run;
        bit ok;
        run = 0;
        ok = 0;
        for (int c = 0; c < 400; c++) begin
            if (!busy) begin
                run++;
            end else begin
                if (run > 0) chk({tag, "_idle_gap"}, run, 1);
                run = 0;
            end
            chk({tag, "_resp_onehot0"}, $onehot0(resp_valid), 1);
            if (req_ready != 0) gq.push_back(first_idx(req_ready));
            if (gq.size() >= want) begin
                ok = 1;
                break;
            end
            cyc();
        end
        chk({tag, "_grants_done"}, ok, 1);
    endtask

    typedef struct {
        int          idx;
        logic [31:0] n;
        logic [31:0] d;
        logic [31:0] q;
    } vec_t;

    typedef struct {
        logic [31:0] n;
        logic [31:0] d;
    } job_t;

    vec_t tbl[6];
    job_t jq[NR][$];

    initial begin
        int exp_order[5];
        int cnt;
        bit seen;
        bit free;
        bit held;
        int owner;
        int ptr;
        int done;
        logic [31:0] expq;
        logic [3:0]  exp_rr;
        logic [3:0]  p_acc;
        logic [3:0]  p_rv;
        logic [3:0]  p_rr;
        logic [31:0] p_data;

        tbl[0] = '{0, 32'h0006_0000, 32'h0002_0000, 32'h0003_0000};
        tbl[1] = '{1, 32'h0001_0000, 32'h0004_0000, 32'h0000_4000};
        tbl[2] = '{3, 32'h0007_0000, 32'h0002_0000, 32'h0003_8000};
        tbl[3] = '{2, 32'h0001_0000, 32'h0003_0000, 32'h0000_5555};
        tbl[4] = '{1, 32'h1234_5678, 32'h0000_0000, 32'hFFFF_FFFF};
        tbl[5] = '{0, 32'hFFFF_0000, 32'h0001_0000, 32'hFFFF_0000};

        rst = 1'b1;
        req_valid = '0;
        resp_ready = '0;
        req_n = '0;
        req_d = '0;
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_div_in_valid", div_in_valid, 0);
        chk("rst_div_n", div_n, 0);
        chk("rst_div_d", div_d, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_grant_id", grant_id, 0);
        cyc();
        rst = 1'b0;
        cyc();

        // Table of single jobs.
        dv_lat = 3;
        for (int v = 0; v < 6; v++) begin
            run_single(tbl[v].idx, tbl[v].n, tbl[v].d, tbl[v].q,
                       $sformatf("vec%0d", v));
        end

        // All requesters contending.
        do_reset();
        dv_lat = 2;
        for (int i = 0; i < NR; i++) set_req(i, 32'((i + 1) << 16), 32'h0001_0000);
        resp_ready = '1;
        req_valid = '1;
        #1;
        gq.delete();
        collect(5, "cont");
        exp_order = '{0, 1, 2, 3, 0};
        for (int g = 0; g < 5; g++) begin
            chk($sformatf("cont_order%0d", g), (gq.size() > g) ? gq[g] : -1,
                exp_order[g]);
        end
        drain();

        // Pointer moves past the last served requester.
        do_reset();
        run_single(2, 32'h0008_0000, 32'h0004_0000, 32'h0002_0000, "rr_pre");
        set_req(1, 32'h0003_0000, 32'h0001_0000);
        set_req(3, 32'h0005_0000, 32'h0001_0000);
        req_valid = 4'b1010;
        resp_ready = '1;
        #1;
        gq.delete();
        collect(2, "rr");
        chk("rr_first", (gq.size() > 0) ? gq[0] : -1, 3);
        chk("rr_second", (gq.size() > 1) ? gq[1] : -1, 1);
        drain();

        // Divider backpressure for 5 cycles.
        dv_lat = 2;
        set_req(0, 32'h000A_0000, 32'h0005_0000);
        resp_ready = '1;
        dv_stall = 5;
        req_valid = 4'b0001;
        #1;
        chk("bp_req_ready", req_ready, 4'b0001);
        cnt = 0;
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            cyc();
            if (c == 0) req_valid = '0;
            if (div_in_valid) begin
                cnt++;
                chk("bp_div_n_stable", div_n, 32'h000A_0000);
                chk("bp_div_d_stable", div_d, 32'h0005_0000);
            end
            if (resp_valid != 0) begin
                seen = 1;
                break;
            end
        end
        chk("bp_issue_cycles", cnt, 5);
        chk("bp_resp_seen", seen, 1);
        chk("bp_resp_data", resp_data, 32'h0002_0000);
        drain();

        // Response backpressure for 3 cycles.
        set_req(0, 32'h0009_0000, 32'h0003_0000);
        resp_ready = '0;
        req_valid = 4'b0001;
        #1;
        cyc();
        req_valid = '0;
        seen = 0;
        for (int c = 0; c < 50; c++) begin
            if (resp_valid != 0) begin
                seen = 1;
                break;
            end
            cyc();
        end
        chk("rbp_resp_seen", seen, 1);
        set_req(1, 32'h0004_0000, 32'h0002_0000);
        req_valid = 4'b0010;
        resp_ready = 4'b1110;
        for (int k = 0; k < 3; k++) begin
            cyc();
            chk("rbp_hold_valid", resp_valid, 4'b0001);
            chk("rbp_hold_data", resp_data, 32'h0003_0000);
            chk("rbp_no_accept", req_ready, 0);
        end
        resp_ready = 4'b0001;
        cyc();
        chk("rbp_released", busy, 0);
        chk("rbp_next_grant", req_ready, 4'b0010);
        cyc();
        drain();

        // Reset while waiting on the divider; stale result must vanish.
        dv_lat = 8;
        set_req(2, 32'h0004_0000, 32'h0001_0000);
        req_valid = 4'b0100;
        resp_ready = '1;
        #1;
        cyc();
        req_valid = '0;
        cyc();
        chk("mid_in_wait", {div_in_valid, busy}, 2'b01);
        rst = 1'b1;
        #1;
        chk("mid_async_busy", busy, 0);
        cyc();
        rst = 1'b0;
        for (int c = 0; c < 12; c++) begin
            cyc();
            chk("mid_no_resp", resp_valid, 0);
            chk("mid_idle", busy, 0);
        end
        chk("mid_grant_id", grant_id, 0);
        set_req(0, 32'h0006_0000, 32'h0003_0000);
        set_req(3, 32'h0001_0000, 32'h0001_0000);
        req_valid = 4'b1001;
        #1;
        chk("mid_ptr_zero", req_ready, 4'b0001);
        req_valid = '0;
        dv_lat = 2;
        run_single(0, 32'h0006_0000, 32'h0003_0000, 32'h0002_0000, "mid_after");

        // Randomized traffic against a transaction-level model.
        do_reset();
        for (int i = 0; i < NR; i++) begin
            for (int j = 0; j < 6; j++) begin
                job_t jb;
                jb.n = $urandom;
                jb.d = ($urandom_range(0, 7) == 0) ? 32'h0 : $urandom;
                jq[i].push_back(jb);
            end
        end
        dv_rand = 1;
        free = 1;
        owner = 0;
        ptr = 0;
        done = 0;
        expq = '0;
        p_acc = '0;
        p_rv = '0;
        p_rr = '0;
        p_data = '0;
        for (int c = 0; c < 6000 && done < NR * 6; c++) begin
            cyc();
            held = 0;
            if (!free && (p_rv & p_rr & oh(owner)) != 0) begin
                free = 1;
                ptr = (owner + 1) % NR;
                done++;
            end else if (p_acc != 0) begin
                owner = first_idx(p_acc);
                free = 0;
                expq = ref_div(jq[owner][0].n, jq[owner][0].d);
                void'(jq[owner].pop_front());
            end else if (!free && p_rv != 0) begin
                held = 1;
            end
            for (int i = 0; i < NR; i++) begin
                if (jq[i].size() > 0) set_req(i, jq[i][0].n, jq[i][0].d);
                req_valid[i] = (jq[i].size() > 0) && ($urandom_range(0, 3) != 0);
                resp_ready[i] = 1'($urandom_range(0, 1));
            end
            #1;
            exp_rr = '0;
            if (free) begin
                for (int k = 0; k < NR; k++) begin
                    if (req_valid[(ptr + k) % NR]) begin
                        exp_rr = oh((ptr + k) % NR);
                        break;
                    end
                end
            end
            chk("rnd_req_ready", req_ready, exp_rr);
            chk("rnd_busy", busy, !free);
            if (held) begin
                chk("rnd_resp_hold", resp_valid, oh(owner));
                chk("rnd_data_hold", resp_data, p_data);
            end
            if (resp_valid != 0) begin
                chk("rnd_resp_owner", resp_valid, free ? 4'b0 : oh(owner));
                chk("rnd_resp_data", resp_data, expq);
                chk("rnd_resp_err", resp_err, 0);
            end
            p_acc = req_valid & req_ready;
            p_rv = resp_valid;
            p_rr = resp_ready;
            p_data = resp_data;
        end
        chk("rnd_all_done", done, NR * 6);
        dv_rand = 0;
        drain();

        // Divider that never answers.
        do_reset();
        dv_lat = 2;
        dv_mute = 1;
        set_req(0, 32'h0001_0000, 32'h0001_0000);
        req_valid = 4'b0001;
        resp_ready = '0;
        #1;
        cyc();
        req_valid = '0;
        cyc();
`ifdef DIV_TIMEOUT_EN
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
            if (resp_valid != 0) break;
            cnt++;
            cyc();
        end
        chk("tmo_wait_cycles", cnt, 8);
        chk("tmo_resp_valid", resp_valid, 4'b0001);
        chk("tmo_resp_data", resp_data, 32'h7FFF_FFFF);
        chk("tmo_resp_err", resp_err, 1);
        resp_ready = 4'b0001;
        cyc();
        chk("tmo_idle_after", busy, 0);
`else
        for (int c = 0; c < 40; c++) begin
            cyc();
            chk("hang_busy", busy, 1);
            chk("hang_no_resp", resp_valid, 0);
        end
        do_reset();
`endif
        dv_mute = 0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
